pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central sequencing and hazard unit for the 5-stage PipelinedARMv8 core (IF, ID, EX, MEM, WB).
- Keeps its own shadow tag pipeline of register usage for the ID/EX, EX/MEM and MEM/WB slots.
- Generates PC/IF-ID write enables, flushes, bubbles and EX-stage forwarding selects.
- Also sequences start-up hold after reset and global freeze while data memory is busy.

Parameters:
- RESET_HOLD_CYCLES, 4, cycles after reset release during which the pipeline stays frozen (instruction/register memories settle).
- MEM_TIMEOUT, 16, max consecutive mem_busy cycles before error is flagged.
- CNT_W, 16, width of saturating performance counters.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- id_rn  input  5  Rn of instruction in ID.
- id_rm  input  5  Rm (or Rt for STUR/CBZ) of instruction in ID.
- id_rd  input  5  destination of instruction in ID (30 for BL).
- id_uses_rn  input  1  ID instruction reads Rn.
- id_uses_rm  input  1  ID instruction reads Rm/Rt.
- id_regwrite  input  1  ID instruction writes id_rd.
- id_memread  input  1  ID instruction is a load (LDUR).
- ex_branch_taken  input  1  branch in EX resolved taken (B, BL, taken CBZ/B.cond).
- mem_busy  input  1  data memory cannot complete this cycle.
- pc_write_en  output  1  PC may update.
- if_id_write_en  output  1  IF/ID register may load.
- if_id_flush  output  1  IF/ID loads a NOP.
- id_ex_bubble  output  1  ID/EX loads a NOP.
- fwd_a  output  2  EX operand A select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- fwd_b  output  2  same for operand B.
- freeze  output  1  all pipeline registers hold.
- error  output  1  sticky memory timeout.
- stall_count  output  CNT_W  load-use stall cycles, saturating.
- flush_count  output  CNT_W  taken-branch flushes, saturating.

Behaviour:
- Reset values: state HOLD, all tags invalid, counters 0, error 0. Outputs in HOLD: pc_write_en=0, if_id_write_en=0, freeze=1, if_id_flush=0, id_ex_bubble=0, fwd_a=fwd_b=00.
- Tag contents (EX, MEM, WB slots): valid, rd, regwrite, memread, plus rn/rm/uses_rn/uses_rm for EX.
  - A tag with rd=31 (XZR) never matches: no stall, no forward.
- FSM:
  - HOLD: counts RESET_HOLD_CYCLES edges after reset falls, then -> RUN.
  - RUN: normal operation. mem_busy=1 -> FREEZE; the cycle that sees mem_busy already outputs freeze=1, both enables 0, and tags hold.
  - FREEZE: same freeze outputs; internal busy counter increments. Exit to RUN in the first cycle mem_busy=0, with RUN behaviour in that same cycle. Counter reaching MEM_TIMEOUT -> error=1 (sticky until reset), state stays FREEZE while busy.
  - Reset asserted in any state -> HOLD immediately, all tags cleared.
- RUN, combinational per cycle:
  - Load-use: EX tag valid & memread & regwrite & rd≠31 & ((id_uses_rn & id_rn==rd) | (id_uses_rm & id_rm==rd)).
    - Response: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1.
    - Stall lasts exactly 1 cycle; stall_count++.
  - Taken branch: ex_branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1 (target loads), if_id_write_en=1; flush_count++.
    - Branch has priority over load-use; no stall is counted that cycle.
  - Otherwise: pc_write_en=1, if_id_write_en=1, no flush/bubble.
- Tag advance at each RUN edge: WB<=MEM, MEM<=EX, EX<=ID fields (or invalid if bubble). FREEZE/HOLD: tags hold.
- Forwarding, computed for the EX tag, evaluated in all states:
  - fwd_a=10 if MEM tag valid&regwrite&rd≠31&ex.uses_rn&ex.rn==MEM.rd.
  - Else fwd_a=01 on the equivalent WB match.
  - Else 00. fwd_b is the same using rm.
  - MEM always beats WB.
- WB→ID same-cycle hazard is not handled here; the register file provides write-through.
- Counters saturate at all-ones.

Test Plan:
- Reset high 15 ns then low, RESET_HOLD_CYCLES=4 -> pc_write_en=0/freeze=1 for exactly 4 rising edges, then pc_write_en=1.
- LDUR X9,[X16] followed by ADD X2,X9,X18 -> one cycle of pc_write_en=0, id_ex_bubble=1; stall_count=1; ADD then gets fwd_a=01.
- ADD X2,X16,X18 then SUB X3,X2,X2 -> SUB in EX sees fwd_a=fwd_b=10; with one NOP between -> 01.
- B #24 with ex_branch_taken=1 -> if_id_flush=1, id_ex_bubble=1 for one cycle, flush_count=1. Simultaneous load-use -> stall_count unchanged.
- BL #8 (rd=30) then ADD X4,X30,X16 -> fwd_a=10; ADD X4,XZR,X16 after any writer of X31 -> fwd_a=00, no stall.
- mem_busy held 3 cycles -> freeze=1 for 3 cycles, tags unchanged. Held 16 cycles -> error=1 and it stays 1 after mem_busy drops, until reset.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing unit for the 5-stage ARMv8 pipeline: start-up hold, data-memory
// freeze with timeout, load-use stall, taken-branch flush and EX-stage forwarding selects.
module pipeline_hazard_controller #(
   parameter int RESET_HOLD_CYCLES = 4,
   parameter int MEM_TIMEOUT       = 16,
   parameter int CNT_W             = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       id_rn,
   input  logic [4:0]       id_rm,
   input  logic [4:0]       id_rd,
   input  logic             id_uses_rn,
   input  logic             id_uses_rm,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_write_en,
   output logic             if_id_write_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             freeze,
   output logic             error,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [4:0] XZR = 5'd31;
   localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
   localparam int BUSY_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(MEM_TIMEOUT - 1);
   localparam logic [BUSY_W-1:0] BUSY_MAX  = BUSY_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FREEZE = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
      logic [4:0] rn;
      logic [4:0] rm;
      logic       uses_rn;
      logic       uses_rm;
   } ex_tag_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
   } wb_tag_t;

   localparam ex_tag_t EX_EMPTY = '0;
   localparam wb_tag_t WB_EMPTY = '0;

   function automatic logic reg_hit(input wb_tag_t t, input logic [4:0] r);
      return t.valid & t.regwrite & (t.rd != XZR) & (t.rd == r);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                          input wb_tag_t m, input wb_tag_t w);
      logic [1:0] sel;
      if (use_r && reg_hit(m, r)) begin
         sel = 2'b10;
      end else if (use_r && reg_hit(w, r)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
   logic              error_q, error_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   ex_tag_t           ex_q, ex_d;
   wb_tag_t           mem_q, mem_d;
   wb_tag_t           wb_q, wb_d;
   logic              load_use_s;
   logic              active_s;
   logic              run_s;
   logic              unused_memread_s;

   // memread only matters while the load sits in EX
   assign unused_memread_s = mem_q.memread ^ wb_q.memread;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_HOLD;
         hold_cnt_q <= {HOLD_W{1'b0}};
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d    = ST_RUN;
               hold_cnt_d = {HOLD_W{1'b0}};
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         ST_RUN: begin
            if (mem_busy) state_d = ST_FREEZE;
            else          state_d = ST_RUN;
         end
         ST_FREEZE: begin
            if (mem_busy) state_d = ST_FREEZE;
            else          state_d = ST_RUN;
         end
         default: begin
            state_d    = ST_HOLD;
            hold_cnt_d = {HOLD_W{1'b0}};
         end
      endcase
   end

   always_comb begin
      active_s   = (state_q == ST_RUN) | (state_q == ST_FREEZE);
      run_s      = active_s & ~mem_busy;
      load_use_s = ex_q.valid & ex_q.memread & ex_q.regwrite & (ex_q.rd != XZR) &
                   ((id_uses_rn & (id_rn == ex_q.rd)) | (id_uses_rm & (id_rm == ex_q.rd)));
   end

   // a FREEZE cycle that sees mem_busy low already behaves as RUN
   always_comb begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_bubble   = 1'b0;
      freeze         = 1'b1;
      case (state_q)
         ST_RUN, ST_FREEZE: begin
            if (mem_busy) begin
               freeze = 1'b1;
            end else if (ex_branch_taken) begin
               pc_write_en    = 1'b1;
               if_id_write_en = 1'b1;
               if_id_flush    = 1'b1;
               id_ex_bubble   = 1'b1;
               freeze         = 1'b0;
            end else if (load_use_s) begin
               id_ex_bubble   = 1'b1;
               freeze         = 1'b0;
            end else begin
               pc_write_en    = 1'b1;
               if_id_write_en = 1'b1;
               freeze         = 1'b0;
            end
         end
         default: begin
            freeze = 1'b1;
         end
      endcase
      fwd_a = fwd_sel(ex_q.uses_rn, ex_q.rn, mem_q, wb_q);
      fwd_b = fwd_sel(ex_q.uses_rm, ex_q.rm, mem_q, wb_q);
   end

   always_comb begin
      ex_d        = ex_q;
      mem_d       = mem_q;
      wb_d        = wb_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      error_d     = error_q;
      busy_cnt_d  = {BUSY_W{1'b0}};
      if (active_s && mem_busy) begin
         busy_cnt_d = (busy_cnt_q == BUSY_MAX) ? busy_cnt_q : busy_cnt_q + BUSY_W'(1);
         if (busy_cnt_q >= BUSY_LAST) error_d = 1'b1;
         else                         error_d = error_q;
      end else begin
         busy_cnt_d = {BUSY_W{1'b0}};
      end
      if (run_s) begin
         wb_d  = mem_q;
         mem_d = '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite, memread: ex_q.memread};
         if (id_ex_bubble) begin
            ex_d = EX_EMPTY;
         end else begin
            ex_d = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread,
                     rn: id_rn, rm: id_rm, uses_rn: id_uses_rn, uses_rm: id_uses_rm};
         end
         if (ex_branch_taken)  flush_cnt_d = sat_inc(flush_cnt_q);
         else if (load_use_s)  stall_cnt_d = sat_inc(stall_cnt_q);
         else                  stall_cnt_d = stall_cnt_q;
      end else begin
         ex_d = ex_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ex_q        <= EX_EMPTY;
         mem_q       <= WB_EMPTY;
         wb_q        <= WB_EMPTY;
         busy_cnt_q  <= {BUSY_W{1'b0}};
         error_q     <= 1'b0;
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         busy_cnt_q  <= busy_cnt_d;
         error_q     <= error_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign error       = error_q;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus random traffic,
// all checked against a slot-array reference model of the hazard rules.
module tb_pipeline_hazard_controller;

   localparam int HOLD    = 4;
   localparam int TIMEOUT = 16;
   localparam int CW      = 4;
   localparam int CMAX    = (1 << CW) - 1;
   localparam logic [17:0] RESET_V = 18'h00200;

   logic clock = 1'b1;
   logic reset = 1'b1;
   logic [4:0] id_rn = 5'd0, id_rm = 5'd0, id_rd = 5'd0;
   logic id_uses_rn = 1'b0, id_uses_rm = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;
   logic ex_branch_taken = 1'b0, mem_busy = 1'b0;
   logic pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, freeze, error;
   logic [1:0] fwd_a, fwd_b;
   logic [CW-1:0] stall_count, flush_count;
   logic [17:0] obs_v, exp_v;

   always #5 clock = ~clock;

   pipeline_hazard_controller #(.RESET_HOLD_CYCLES(HOLD), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .freeze(freeze), .error(error),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   assign obs_v = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
                   freeze, error, stall_count, flush_count};

   int checks = 0;
   int failures = 0;

   // reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
   typedef struct {
      bit v; bit [4:0] rd; bit [4:0] rn; bit [4:0] rm;
      bit rw; bit mr; bit urn; bit urm;
   } slot_t;
   slot_t pipe [3];
   int hold_left, busy_run, m_stalls, m_flushes;
   bit m_err, e_hold, e_run, e_lu, e_pc, e_ifid, e_fl, e_bub, e_frz;
   bit [1:0] e_fa, e_fb;

   function automatic bit hits(slot_t s, bit [4:0] r);
      return s.v && s.rw && (s.rd != 5'd31) && (s.rd == r);
   endfunction

   function automatic bit [1:0] pick(bit u, bit [4:0] r, slot_t m, slot_t w);
      if (u && hits(m, r)) return 2'b10;
      if (u && hits(w, r)) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
      hold_left = HOLD; busy_run = 0; m_stalls = 0; m_flushes = 0; m_err = 1'b0;
   endtask

   task automatic model_eval();
      e_hold = (hold_left > 0);
      e_run  = !e_hold && !mem_busy;
      e_lu   = pipe[0].v && pipe[0].mr && pipe[0].rw && (pipe[0].rd != 5'd31) &&
               ((id_uses_rn && id_rn == pipe[0].rd) || (id_uses_rm && id_rm == pipe[0].rd));
      e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 0; e_frz = 1;
      if (e_run) begin
         e_frz = 0;
         if (ex_branch_taken) begin e_pc = 1; e_ifid = 1; e_fl = 1; e_bub = 1; end
         else if (e_lu)       begin e_bub = 1; end
         else                 begin e_pc = 1; e_ifid = 1; end
      end
      e_fa = pick(pipe[0].urn, pipe[0].rn, pipe[1], pipe[2]);
      e_fb = pick(pipe[0].urm, pipe[0].rm, pipe[1], pipe[2]);
      exp_v = {e_pc, e_ifid, e_fl, e_bub, e_fa, e_fb, e_frz, m_err, CW'(m_stalls), CW'(m_flushes)};
   endtask

   task automatic model_update();
      if (e_run && ex_branch_taken)  m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
      else if (e_run && e_lu)        m_stalls  = (m_stalls  < CMAX) ? m_stalls + 1  : CMAX;
      if (!e_hold && mem_busy) begin
         busy_run++;
         if (busy_run >= TIMEOUT) m_err = 1'b1;
      end else begin
         busy_run = 0;
      end
      if (e_hold) hold_left--;
      if (e_run) begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         if (e_bub) pipe[0] = '{default: 0};
         else pipe[0] = '{1'b1, id_rd, id_rn, id_rm, id_regwrite, id_memread, id_uses_rn, id_uses_rm};
      end
   endtask

   task automatic drive(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                        input logic urn, input logic urm, input logic rw, input logic mr,
                        input logic br, input logic busy);
      id_rn = rn; id_rm = rm; id_rd = rd;
      id_uses_rn = urn; id_uses_rm = urm; id_regwrite = rw; id_memread = mr;
      ex_branch_taken = br; mem_busy = busy;
      model_eval();
      @(negedge clock);
   endtask

   task automatic step();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_v !== RESET_V) begin
         failures++; $display("FAIL reset_state got=%h exp=%h", obs_v, RESET_V);
      end
      #10;
      reset = 1'b0;
      step();
      for (int i = 0; i < HOLD; i++) begin
         drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
         checks++;
         if (pc_write_en !== (i == HOLD - 1) || freeze !== (i != HOLD - 1)) begin
            failures++; $display("FAIL hold_window i=%0d got pc=%b frz=%b", i, pc_write_en, freeze);
         end
         checks++;
         if (obs_v !== exp_v) begin
            failures++; $display("FAIL hold_vec i=%0d got=%h exp=%h", i, obs_v, exp_v);
         end
         step();
      end
   endtask

   task automatic test_load_use();
      drive(5'd16, 5'd0, 5'd9, 1, 0, 1, 1, 0, 0);          // LDUR X9,[X16]
      step();
      drive(5'd9, 5'd18, 5'd2, 1, 1, 1, 0, 0, 0);          // ADD X2,X9,X18
      checks++;
      if (pc_write_en !== 1'b0 || id_ex_bubble !== 1'b1 || if_id_write_en !== 1'b0) begin
         failures++; $display("FAIL lu_stall got pc=%b bub=%b exp pc=0 bub=1", pc_write_en, id_ex_bubble);
      end
      step();
      drive(5'd9, 5'd18, 5'd2, 1, 1, 1, 0, 0, 0);
      checks++;
      if (pc_write_en !== 1'b1 || id_ex_bubble !== 1'b0 || stall_count !== 4'd1) begin
         failures++; $display("FAIL lu_release got pc=%b bub=%b stalls=%0d exp 1 0 1",
                              pc_write_en, id_ex_bubble, stall_count);
      end
      step();
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b00 || obs_v !== exp_v) begin
         failures++; $display("FAIL lu_fwd got fa=%b fb=%b vec=%h exp fa=01 fb=00 vec=%h",
                              fwd_a, fwd_b, obs_v, exp_v);
      end
      step();
   endtask

   task automatic test_forward();
      drive(5'd16, 5'd18, 5'd2, 1, 1, 1, 0, 0, 0); step(); // ADD X2,X16,X18
      drive(5'd2, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0);   step(); // SUB X3,X2,X2
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
         failures++; $display("FAIL fwd_mem got fa=%b fb=%b exp 10 10", fwd_a, fwd_b);
      end
      step();
      drive(5'd16, 5'd18, 5'd2, 1, 1, 1, 0, 0, 0); step();
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);   step();
      drive(5'd2, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0);   step();
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b01 || obs_v !== exp_v) begin
         failures++; $display("FAIL fwd_wb got fa=%b fb=%b vec=%h exp 01 01 vec=%h", fwd_a, fwd_b, obs_v, exp_v);
      end
      step();
   endtask

   task automatic test_branch();
      int f0, s0;
      f0 = m_flushes;
      drive(5'd2, 5'd3, 5'd1, 1, 1, 1, 0, 1, 0);          // branch taken in EX
      checks++;
      if (if_id_flush !== 1'b1 || id_ex_bubble !== 1'b1 || pc_write_en !== 1'b1 || if_id_write_en !== 1'b1) begin
         failures++; $display("FAIL br_flush got fl=%b bub=%b pc=%b exp 1 1 1", if_id_flush, id_ex_bubble, pc_write_en);
      end
      step();
      drive(5'd3, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0);          // LDUR X5,[X3]
      checks++;
      if (if_id_flush !== 1'b0 || flush_count !== CW'(f0 + 1)) begin
         failures++; $display("FAIL br_count got fl=%b cnt=%0d exp 0 %0d", if_id_flush, flush_count, f0 + 1);
      end
      step();
      s0 = m_stalls;
      drive(5'd5, 5'd5, 5'd6, 1, 1, 1, 0, 1, 0);          // ADD X6,X5,X5 with branch taken
      checks++;
      if (if_id_flush !== 1'b1 || id_ex_bubble !== 1'b1 || pc_write_en !== 1'b1) begin
         failures++; $display("FAIL br_prio got fl=%b bub=%b pc=%b exp 1 1 1", if_id_flush, id_ex_bubble, pc_write_en);
      end
      step();
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (stall_count !== CW'(s0) || flush_count !== CW'(f0 + 2)) begin
         failures++; $display("FAIL br_nostall got st=%0d fc=%0d exp %0d %0d", stall_count, flush_count, s0, f0 + 2);
      end
      step();
   endtask

   task automatic test_xzr();
      drive(5'd0, 5'd0, 5'd30, 0, 0, 1, 0, 0, 0);   step(); // BL #8
      drive(5'd30, 5'd16, 5'd4, 1, 1, 1, 0, 0, 0);  step(); // ADD X4,X30,X16
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
         failures++; $display("FAIL bl_fwd got fa=%b fb=%b exp 10 00", fwd_a, fwd_b);
      end
      step();
      drive(5'd1, 5'd0, 5'd31, 1, 0, 1, 1, 0, 0);   step(); // LDUR XZR,[X1]
      drive(5'd31, 5'd16, 5'd4, 1, 1, 1, 0, 0, 0);          // ADD X4,XZR,X16
      checks++;
      if (pc_write_en !== 1'b1 || id_ex_bubble !== 1'b0) begin
         failures++; $display("FAIL xzr_nostall got pc=%b bub=%b exp 1 0", pc_write_en, id_ex_bubble);
      end
      step();
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (fwd_a !== 2'b00 || obs_v !== exp_v) begin
         failures++; $display("FAIL xzr_fwd got fa=%b vec=%h exp 00 vec=%h", fwd_a, obs_v, exp_v);
      end
      step();
   endtask

   task automatic test_freeze();
      drive(5'd1, 5'd2, 5'd7, 1, 1, 1, 0, 0, 0);  step(); // ADD X7,X1,X2
      drive(5'd7, 5'd7, 5'd8, 1, 1, 1, 0, 0, 0);  step(); // ADD X8,X7,X7
      for (int i = 0; i < 3; i++) begin
         drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
         checks++;
         if (freeze !== 1'b1 || pc_write_en !== 1'b0 || if_id_write_en !== 1'b0 ||
             fwd_a !== 2'b10 || fwd_b !== 2'b10 || obs_v !== exp_v) begin
            failures++; $display("FAIL freeze_hold i=%0d got=%h exp=%h", i, obs_v, exp_v);
         end
         step();
      end
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (freeze !== 1'b0 || pc_write_en !== 1'b1 || fwd_a !== 2'b10 || error !== 1'b0) begin
         failures++; $display("FAIL freeze_exit got frz=%b pc=%b fa=%b err=%b exp 0 1 10 0",
                              freeze, pc_write_en, fwd_a, error);
      end
      step();
   endtask

   task automatic test_timeout();
      for (int i = 0; i < TIMEOUT; i++) begin
         drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
         checks++;
         if (error !== 1'b0 || freeze !== 1'b1) begin
            failures++; $display("FAIL timeout_early i=%0d got err=%b frz=%b exp 0 1", i, error, freeze);
         end
         step();
      end
      for (int i = 0; i < 3; i++) begin
         drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
         checks++;
         if (error !== 1'b1 || obs_v !== exp_v) begin
            failures++; $display("FAIL timeout_sticky i=%0d got err=%b vec=%h exp err=1 vec=%h",
                                 i, error, obs_v, exp_v);
         end
         step();
      end
   endtask

   task automatic test_random();
      logic [4:0] r [3];
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 3; k++)
            r[k] = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(1, 4));
         drive(r[0], r[1], r[2], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
         checks++;
         if (obs_v !== exp_v) begin
            failures++; $display("FAIL random_vec n=%0d got=%h exp=%h", n, obs_v, exp_v);
         end
         step();
      end
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      if (m_flushes == CMAX) begin
         checks++;
         if (flush_count !== 4'hF) begin
            failures++; $display("FAIL flush_saturate got=%0d exp=15", flush_count);
         end
      end
      step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_use();
      test_forward();
      test_branch();
      test_xzr();
      test_freeze();
      test_timeout();
      test_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
